ff_puf_eval_ctrl: RTL and testbench
===================================

Name: ff_puf_eval_ctrl

Overview:
- Parametrised evaluation controller for the feed-forward arbiter PUF fabric.
- Accepts a challenge seed, expands it on-chip into RESP_W per-bit challenges with a Galois LFSR, and fires the external race fabric N_EVAL times per challenge.
- Majority-votes each captured arbiter bit and returns a RESP_W-bit response plus an instability count over a valid/ready handshake.
- Sits between the host/UART request path and the placed delay-chain fabric; the delay chain, its feed-forward arbiters and its placement constraints stay outside this block.

Parameters:
- N_STAGES, 64, challenge width and number of mux stages in the fabric.
- RESP_W, 8, response bits per request.
- N_EVAL, 5, evaluations per response bit; must be odd. An even value is an elaboration error.
- SETTLE_CYC, 4, cycles launch_o is held high before sampling; must be ≥ 1.
- LFSR_POLY, 64'hD800_0000_0000_0000, Galois feedback mask, N_STAGES wide.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  seed request valid
- req_ready  out  1  controller idle, can accept a seed
- req_seed  in  N_STAGES  challenge seed
- chal_o  out  N_STAGES  challenge driven to the mux select lines
- arb_clr_o  out  1  clears the fabric arbiter and feed-forward flops
- launch_o  out  1  race launch edge into the chain input
- arb_i  in  1  final arbiter output, treated as already synchronised
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  RESP_W  voted response, bit k from challenge k
- rsp_unstable  out  clog2(RESP_W+1)  count of bits with non-unanimous votes

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, req_ready=1.
  - chal_o=0, arb_clr_o=0, launch_o=0.
  - rsp_valid=0, rsp_data=0, rsp_unstable=0.
  - All counters 0.
- States: IDLE, CLR, FIRE, SAMP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: chal_o<=req_seed, or 1 if req_seed==0. Clear tally, eval counter, bit index and unstable count. Go to CLR.
- CLR (1 cycle): arb_clr_o=1, launch_o=0. Go to FIRE.
- FIRE (SETTLE_CYC cycles): launch_o=1, arb_clr_o=0. Go to SAMP.
- SAMP (1 cycle):
  - launch_o=0; tally += arb_i.
  - If eval < N_EVAL-1: eval++, go to CLR.
  - Else:
    - rsp_data[bit] <= (tally_incl_this > N_EVAL/2).
    - If tally_incl_this is neither 0 nor N_EVAL, unstable++.
    - Clear tally and eval counter.
    - If bit < RESP_W-1: bit++, chal_o <= (chal_o>>1) ^ (chal_o[0] ? LFSR_POLY : 0), go to CLR.
    - Else go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_unstable held stable.
  - On rsp_ready: rsp_valid<=0, go to IDLE.
  - chal_o holds its last value.
- Cycle cost: each evaluation is SETTLE_CYC+2 cycles. rsp_valid rises RESP_W*N_EVAL*(SETTLE_CYC+2)+1 clocks after the accepting edge.
- Handshakes:
  - req_ready=0 in every state except IDLE; req_valid outside IDLE is ignored.
  - No combinational path from rsp_ready to req_ready. The next seed is accepted no earlier than the cycle after the response handshake.
- Counter widths: tally and eval counters are clog2(N_EVAL+1) wide, bit index is clog2(RESP_W) wide; none of them wrap.
- Reset mid-operation: launch_o and arb_clr_o drop asynchronously. Any partial response is discarded and rsp_valid stays 0.
- All outputs are registered.

Optional Feature:
- Macro: PUF_LED_EN.
- Defined:
  - Adds output led_o[1:0], reset to 2'b01.
  - On each DONE entry, led_o <= rsp_data[0] ? 2'b10 : 2'b01. Holds between responses.
- Undefined: led_o and its register are absent; all other behaviour is identical.

Test Plan:
- Bench parameters: N_STAGES=8, RESP_W=4, N_EVAL=3, SETTLE_CYC=2, LFSR_POLY=8'hB8.
- Reset values: hold rst_n=0 with random inputs.
  - Required: req_ready=1, launch_o=0, arb_clr_o=0, rsp_valid=0, rsp_data=0, chal_o=0.
- Constant arbiter: arb_i=1, seed 8'h01.
  - Required: chal_o sequence 01, B8, 5C, 2E; 3 launch pulses per challenge, each 2 cycles wide.
  - Required: rsp_valid exactly 49 clocks after accept; rsp_data=4'hF, rsp_unstable=0.
- Noisy votes: arb_i per evaluation = 1,0,1 for every bit.
  - Required: rsp_data=4'hF, rsp_unstable=4.
  - Repeat with 0,1,0: required rsp_data=4'h0, rsp_unstable=4.
- Zero seed: req_seed=8'h00.
  - Required: first chal_o=8'h01, second 8'hB8.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid, with req_valid=1 throughout.
  - Required: rsp_valid, rsp_data and rsp_unstable stable; req_ready=0; no launch pulses.
  - Raise rsp_ready: required rsp_valid=0 and req_ready=1 on the next edge; the new seed is accepted on the edge after that.
- Mid-operation reset: assert rst_n=0 during FIRE.
  - Required: launch_o=0 within the same cycle, asynchronously.
  - Required after release: req_ready=1 and no rsp_valid until a new full request completes.
  - With PUF_LED_EN defined: led_o=2'b01 after reset, 2'b10 after the constant-arbiter response.

Source files
------------

// File: rtl/ff_puf_eval_ctrl.sv
// Feed-forward arbiter PUF evaluation controller: seed -> LFSR challenges -> N_EVAL races per bit -> majority vote (PUF_LED_EN adds led_o).
// Latency: rsp_valid rises RESP_W*N_EVAL*(SETTLE_CYC+2)+1 clocks after the request is accepted.
// Backpressure: response is held stable until rsp_ready; req_ready is low outside IDLE and returns the cycle after the response handshake.
module ff_puf_eval_ctrl #(
    parameter int                  N_STAGES   = 64,
    parameter int                  RESP_W     = 8,
    parameter int                  N_EVAL     = 5,
    parameter int                  SETTLE_CYC = 4,
    parameter logic [N_STAGES-1:0] LFSR_POLY  = 64'hD800_0000_0000_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [N_STAGES-1:0]         req_seed,
    output logic [N_STAGES-1:0]         chal_o,
    output logic                        arb_clr_o,
    output logic                        launch_o,
    input  logic                        arb_i,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [RESP_W-1:0]           rsp_data,
    output logic [$clog2(RESP_W+1)-1:0] rsp_unstable
`ifdef PUF_LED_EN
    ,
    output logic [1:0]                  led_o
`endif
);

    localparam int EW = $clog2(N_EVAL + 1);
    localparam int BW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int UW = $clog2(RESP_W + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);

    generate
        if (N_EVAL % 2 == 0) begin : g_even_eval
            $error("ff_puf_eval_ctrl: N_EVAL must be odd");
        end
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("ff_puf_eval_ctrl: SETTLE_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, CLR, FIRE, SAMP, DONE} state_t;

    state_t              state, state_nxt;
    logic [N_STAGES-1:0] chal_nxt;
    logic [EW-1:0]       tally, tally_nxt, tally_inc;
    logic [EW-1:0]       eval_cnt, eval_nxt;
    logic [BW-1:0]       bit_idx, bit_nxt;
    logic [SW-1:0]       settle_cnt, settle_nxt;
    logic [RESP_W-1:0]   data_nxt;
    logic [UW-1:0]       unst_nxt;
    logic                vld_nxt;

    always_comb begin
        state_nxt  = state;
        chal_nxt   = chal_o;
        tally_nxt  = tally;
        eval_nxt   = eval_cnt;
        bit_nxt    = bit_idx;
        settle_nxt = settle_cnt;
        data_nxt   = rsp_data;
        unst_nxt   = rsp_unstable;
        vld_nxt    = rsp_valid;
        tally_inc  = tally + EW'(arb_i);

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    // An all-zero seed would lock the LFSR, so substitute 1.
                    chal_nxt  = (req_seed == '0) ? N_STAGES'(1) : req_seed;
                    tally_nxt = '0;
                    eval_nxt  = '0;
                    bit_nxt   = '0;
                    unst_nxt  = '0;
                    state_nxt = CLR;
                end
            end
            CLR: begin
                settle_nxt = '0;
                state_nxt  = FIRE;
            end
            FIRE: begin
                if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                    state_nxt = SAMP;
                end else begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end
            SAMP: begin
                if (eval_cnt < EW'(N_EVAL - 1)) begin
                    tally_nxt = tally_inc;
                    eval_nxt  = eval_cnt + EW'(1);
                    state_nxt = CLR;
                end else begin
                    data_nxt[bit_idx] = (tally_inc > EW'(N_EVAL / 2));
                    if (tally_inc != '0 && tally_inc != EW'(N_EVAL)) begin
                        unst_nxt = rsp_unstable + UW'(1);
                    end
                    tally_nxt = '0;
                    eval_nxt  = '0;
                    if (bit_idx < BW'(RESP_W - 1)) begin
                        bit_nxt   = bit_idx + BW'(1);
                        chal_nxt  = (chal_o >> 1) ^ (chal_o[0] ? LFSR_POLY : '0);
                        state_nxt = CLR;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // rsp_valid is registered one cycle into DONE; only a real handshake leaves.
                if (rsp_valid && rsp_ready) begin
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    vld_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            chal_o       <= '0;
            tally        <= '0;
            eval_cnt     <= '0;
            bit_idx      <= '0;
            settle_cnt   <= '0;
            rsp_data     <= '0;
            rsp_unstable <= '0;
            rsp_valid    <= 1'b0;
            req_ready    <= 1'b1;
            arb_clr_o    <= 1'b0;
            launch_o     <= 1'b0;
        end else begin
            state        <= state_nxt;
            chal_o       <= chal_nxt;
            tally        <= tally_nxt;
            eval_cnt     <= eval_nxt;
            bit_idx      <= bit_nxt;
            settle_cnt   <= settle_nxt;
            rsp_data     <= data_nxt;
            rsp_unstable <= unst_nxt;
            rsp_valid    <= vld_nxt;
            req_ready    <= (state_nxt == IDLE);
            arb_clr_o    <= (state_nxt == CLR);
            launch_o     <= (state_nxt == FIRE);
        end
    end

`ifdef PUF_LED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_o <= 2'b01;
        end else if (state != DONE && state_nxt == DONE) begin
            led_o <= data_nxt[0] ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: tb/tb_ff_puf_eval_ctrl.sv
// Scoreboard bench for ff_puf_eval_ctrl: a fabric model replays per-evaluation votes,
// a spec-level model predicts challenges and responses, a monitor checks what the DUT presents.
module tb_ff_puf_eval_ctrl;

    localparam int         NS    = 8;
    localparam int         RW    = 4;
    localparam int         NE    = 3;
    localparam int         SC    = 2;
    localparam logic [7:0] POLY  = 8'hB8;
    localparam int         LAT   = RW * NE * (SC + 2) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NS-1:0] req_seed = '0;
    logic [NS-1:0] chal_o;
    logic          arb_clr_o;
    logic          launch_o;
    logic          arb_i = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [RW-1:0] rsp_data;
    logic [2:0]    rsp_unstable;
`ifdef PUF_LED_EN
    logic [1:0]    led_o;
`endif

    ff_puf_eval_ctrl #(
        .N_STAGES(NS), .RESP_W(RW), .N_EVAL(NE), .SETTLE_CYC(SC), .LFSR_POLY(POLY)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_seed(req_seed),
        .chal_o(chal_o), .arb_clr_o(arb_clr_o), .launch_o(launch_o), .arb_i(arb_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_unstable(rsp_unstable)
`ifdef PUF_LED_EN
        , .led_o(led_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RW-1:0] data;
        logic [2:0]    unst;
    } rsp_t;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          launch_cnt = 0;
    int          lwidth = 0;
    int          rsp_cnt = 0;
    int          fab_k = 0;
    logic        vld_prev = 1'b0;
    logic [11:0] cur_votes = '0;
    logic [7:0]  exp_chal_q[$];
    logic [7:0]  seen_chal[$];
    rsp_t        exp_q[$];
    logic [RW-1:0] last_data = '0;
    logic [2:0]    last_unst = '0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int seen_at(input int i);
        if (i < seen_chal.size()) return int'(seen_chal[i]);
        return -1;
    endfunction

    // Reference: challenge k is the seed (1 if zero) advanced k times by the Galois LFSR;
    // each bit is the majority of its NE votes, unstable when votes disagree.
    task automatic push_model(input logic [7:0] seed, input logic [11:0] votes);
        int   c, ones, data, unst;
        rsp_t r;
        c    = (seed == 8'h00) ? 1 : int'(seed);
        data = 0;
        unst = 0;
        for (int b = 0; b < RW; b++) begin
            exp_chal_q.push_back(8'(c));
            ones = 0;
            for (int e = 0; e < NE; e++) ones += int'(votes[b*NE + e]);
            if (ones * 2 > NE) data += (1 << b);
            if (ones != 0 && ones != NE) unst++;
            c = (c / 2) ^ ((c % 2 == 1) ? int'(POLY) : 0);
        end
        r.data = RW'(data);
        r.unst = 3'(unst);
        exp_q.push_back(r);
        cur_votes = votes;
        fab_k     = 0;
    endtask

    task automatic do_req(input logic [7:0] seed, input logic [11:0] votes);
        int n;
        int start;
        push_model(seed, votes);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        req_valid = 1'b1;
        req_seed  = seed;
        @(negedge clk);
        req_valid = 1'b0;
        req_seed  = 8'($urandom);
        start = rsp_cnt;
        n = 0;
        while (rsp_cnt == start && n < 300) begin @(negedge clk); n++; end
        check("rsp_arrived", int'(rsp_cnt != start), 1);
        @(negedge clk);
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Fabric model plus output monitor, sampling 1 ns after the falling edge.
    always begin
        rsp_t e;
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (req_valid && req_ready) begin
                accept_cyc = cyc + 1;
                launch_cnt = 0;
                seen_chal.delete();
            end
            if (arb_clr_o) begin
                if (fab_k % NE == 0) begin
                    seen_chal.push_back(chal_o);
                    if (exp_chal_q.size() > 0) check("chal_o", int'(chal_o), int'(exp_chal_q.pop_front()));
                    else check("chal_o_unexpected", int'(chal_o), -1);
                end
                arb_i = (fab_k < RW * NE) ? cur_votes[fab_k] : 1'b0;
                fab_k++;
            end
            if (launch_o) begin
                lwidth++;
            end else if (lwidth > 0) begin
                check("launch_width", lwidth, SC);
                lwidth = 0;
                launch_cnt++;
            end
            if (rsp_valid && !vld_prev) begin
                check("rsp_expected", int'(exp_q.size() > 0), 1);
                check("latency", cyc - accept_cyc, LAT);
                check("launch_count", launch_cnt, RW * NE);
            end
            vld_prev = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", int'(rsp_data), int'(e.data));
                    check("rsp_unstable", int'(rsp_unstable), int'(e.unst));
                end
                last_data = rsp_data;
                last_unst = rsp_unstable;
                rsp_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        logic [RW-1:0] d0;
        logic [2:0]    u0;

        // Reset state under random inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            rsp_ready = 1'($urandom);
            arb_i     = 1'($urandom);
            req_seed  = 8'($urandom);
        end
        #1;
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_launch", int'(launch_o), 0);
        check("rst_arb_clr", int'(arb_clr_o), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_unstable", int'(rsp_unstable), 0);
        check("rst_chal", int'(chal_o), 0);
`ifdef PUF_LED_EN
        check("rst_led", int'(led_o), 1);
`endif
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        arb_i     = 1'b0;
        rst_n     = 1'b1;

        // Constant arbiter.
        do_req(8'h01, 12'hFFF);
        check("const_data", int'(last_data), 'hF);
        check("const_unst", int'(last_unst), 0);
        check("const_chal0", seen_at(0), 'h01);
        check("const_chal1", seen_at(1), 'hB8);
        check("const_chal2", seen_at(2), 'h5C);
        check("const_chal3", seen_at(3), 'h2E);
`ifdef PUF_LED_EN
        check("led_after_const", int'(led_o), 2);
`endif

        // Noisy votes 1,0,1 then 0,1,0 on every bit.
        do_req(8'($urandom), 12'hB6D);
        check("noisy101_data", int'(last_data), 'hF);
        check("noisy101_unst", int'(last_unst), 4);
        do_req(8'($urandom), 12'h492);
        check("noisy010_data", int'(last_data), 'h0);
        check("noisy010_unst", int'(last_unst), 4);

        // Zero seed substitution.
        do_req(8'h00, 12'($urandom));
        check("zero_chal0", seen_at(0), 'h01);
        check("zero_chal1", seen_at(1), 'hB8);

        // Randomized requests.
        for (int i = 0; i < 6; i++) do_req(8'($urandom), 12'($urandom));

        // Backpressure with req_valid held high.
        rsp_ready = 1'b0;
        push_model(8'h3C, 12'($urandom));
        @(negedge clk);
        req_valid = 1'b1;
        req_seed  = 8'h3C;
        @(negedge clk);
        req_seed = 8'hC5;
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        check("bp_valid_seen", int'(rsp_valid), 1);
        d0 = rsp_data;
        u0 = rsp_unstable;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_valid_hold", int'(rsp_valid), 1);
            check("bp_data_hold", int'(rsp_data), int'(d0));
            check("bp_unst_hold", int'(rsp_unstable), int'(u0));
            check("bp_req_ready", int'(req_ready), 0);
            check("bp_no_launch", int'(launch_o), 0);
        end
        @(negedge clk);
        push_model(8'hC5, 12'($urandom));
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_rsp_valid_drop", int'(rsp_valid), 0);
        check("bp_req_ready_rise", int'(req_ready), 1);
        @(negedge clk);
        #1;
        check("bp_next_accepted", int'(req_ready), 0);
        check("bp_next_clr", int'(arb_clr_o), 1);
        req_valid = 1'b0;
        n = rsp_cnt;
        for (int i = 0; i < 300 && rsp_cnt == n; i++) @(negedge clk);
        check("bp_second_rsp", int'(rsp_cnt != n), 1);
        @(negedge clk);

        // Reset during FIRE.
        push_model(8'h5A, 12'hFFF);
        @(negedge clk);
        req_valid = 1'b1;
        req_seed  = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!launch_o && n < 50) begin @(negedge clk); n++; end
        check("mid_fire_reached", int'(launch_o), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_launch", int'(launch_o), 0);
        check("mid_async_clr", int'(arb_clr_o), 0);
        check("mid_rsp_valid", int'(rsp_valid), 0);
        exp_q.delete();
        exp_chal_q.delete();
        fab_k      = 0;
        lwidth     = 0;
        launch_cnt = 0;
        vld_prev   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("mid_req_ready", int'(req_ready), 1);
        check("mid_rsp_valid_after", int'(rsp_valid), 0);
`ifdef PUF_LED_EN
        check("mid_led", int'(led_o), 1);
`endif
        repeat (20) @(negedge clk);
        do_req(8'h01, 12'hFFF);
        check("post_rst_data", int'(last_data), 'hF);
`ifdef PUF_LED_EN
        check("post_rst_led", int'(led_o), 2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
